// File: rtl/toom_8_recompose.sv
// toom_8_recompose: serial recomposition of the 15 signed Toom-8 coefficients
// into the 2048-bit product, sum of c_i * 2^(LIMB_W*i).
// Each accepted coefficient is added to the running carry. The low LIMB_W bits
// become a final limb. The arithmetically shifted remainder becomes the new
// carry, so no adder is wider than COEF_W+1 bits.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where valid
// and ready are both high. A producer holds its data and valid stable until
// that edge. Ready never depends on valid in the same cycle.
module toom_8_recompose #(
  parameter int LIMB_W = 128,
  parameter int N_COEF = 15,
  parameter int COEF_W = 264
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COEF_W-1:0]            coef_in,
  input  logic                         coef_valid,
  output logic                         coef_ready,
  output logic [3:0]                   coef_idx,
  output logic [LIMB_W*(N_COEF+1)-1:0] product,
  output logic                         product_valid,
  input  logic                         product_ready,
  output logic                         overflow,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [COEF_W-1:0] carry;
  logic [3:0]        idx;
  logic [LIMB_W-1:0] limb [0:N_COEF];

  logic [COEF_W:0]   sum;
  logic [COEF_W-1:0] carry_next;
  logic              take;

  assign coef_ready    = (state == ACCUM) && !rst;
  assign take          = coef_valid && coef_ready;
  assign product_valid = (state == HOLD);
  assign coef_idx      = idx;
  assign state_dbg     = state;

  // Exact signed sum of the coefficient and the carry, one bit wider than either.
  assign sum        = {coef_in[COEF_W-1], coef_in} + {carry[COEF_W-1], carry};
  // Arithmetic shift right by one limb, truncated back to COEF_W bits.
  assign carry_next = {{(LIMB_W-1){sum[COEF_W]}}, sum[COEF_W:LIMB_W]};

  // Flatten the limb registers onto the product bus, with limb 0 in the LSBs.
  for (genvar g = 0; g <= N_COEF; g++) begin : g_pack
    assign product[g*LIMB_W +: LIMB_W] = limb[g];
  end

  // Control FSM plus the datapath registers: carry, index, limbs and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      idx      <= '0;
      carry    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i <= N_COEF; i++) begin
        limb[i] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            limb[idx] <= sum[LIMB_W-1:0];
            carry     <= carry_next;
            idx       <= idx + 4'd1;
            if (idx == 4'(N_COEF - 1)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The top limb takes the low bits of the residual carry. Any bits
          // left above it, including a negative sign, mean the total overflowed.
          limb[N_COEF] <= carry[LIMB_W-1:0];
          overflow     <= |carry[COEF_W-1:LIMB_W];
          state        <= HOLD;
        end
        HOLD: begin
          if (product_ready) begin
            state    <= ACCUM;
            idx      <= '0;
            carry    <= '0;
            overflow <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toom_8_recompose.sv
// tb_toom_8_recompose: directed bench for toom_8_recompose. A big-integer
// model sums c_i * 2^(128*i) for each frame. The compare process checks every
// product_valid cycle against that model. Literal limb values pin the model.
module tb_toom_8_recompose;

  localparam int LW = 128;
  localparam int NC = 15;
  localparam int CW = 264;
  localparam int PW = LW * (NC + 1);
  localparam int TW = 2400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] coef_in = '0;
  logic          coef_valid = 1'b0;
  logic          coef_ready;
  logic [3:0]    coef_idx;
  logic [PW-1:0] product;
  logic          product_valid;
  logic          product_ready = 1'b1;
  logic          overflow;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];
  logic          exp_ov_q[$];
  logic [CW-1:0] frame [NC];
  logic [PW-1:0] last_product = '0;
  logic          last_ov = 1'b0;
  int            valid_rises = 0;
  logic          prev_valid = 1'b0;

  toom_8_recompose #(.LIMB_W(LW), .N_COEF(NC), .COEF_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .coef_in       (coef_in),
    .coef_valid    (coef_valid),
    .coef_ready    (coef_ready),
    .coef_idx      (coef_idx),
    .product       (product),
    .product_valid (product_valid),
    .product_ready (product_ready),
    .overflow      (overflow),
    .state_dbg     (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_limb(input string name, input int i, input logic [LW-1:0] exp);
    chk(name, last_product[i*LW +: LW], exp);
  endtask

  // Model: the exact signed total of the frame, as one wide integer
  task automatic model_push();
    logic signed [TW-1:0] total;
    logic signed [TW-1:0] term;
    total = '0;
    for (int i = 0; i < NC; i++) begin
      term  = $signed(frame[i]);
      total = total + (term <<< (LW * i));
    end
    exp_q.push_back(total[PW-1:0]);
    exp_ov_q.push_back(total[TW-1:PW] != '0);
  endtask

  // Driver tasks
  task automatic send_coef(input logic [CW-1:0] c);
    int n = 0;
    @(negedge clk);
    coef_in    = c;
    coef_valid = 1'b1;
    #1;
    while (!coef_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!coef_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got coef_ready=0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic send_frame();
    model_push();
    for (int i = 0; i < NC; i++) send_coef(frame[i]);
    @(negedge clk);
    coef_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_ov_q.delete();
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NC; i++) frame[i] = '0;
  endtask

  task automatic load_square();
    int sq [NC] = '{64009, 1012, 1522, 2036, 2555, 3080, 3612, 4152,
                    147, 164, 170, 164, 145, 112, 64};
    for (int i = 0; i < NC; i++) frame[i] = CW'(sq[i]);
  endtask

  task automatic check_square(input string tag);
    chk_limb({tag, "_limb0"}, 0, 128'd64009);
    chk_limb({tag, "_limb1"}, 1, 128'd1012);
    chk_limb({tag, "_limb2"}, 2, 128'd1522);
    chk_limb({tag, "_limb7"}, 7, 128'd4152);
    chk_limb({tag, "_limb14"}, 14, 128'd64);
    chk_limb({tag, "_limb15"}, 15, 128'd0);
    chk({tag, "_ovf"}, LW'(last_ov), 128'd0);
  endtask

  // Scoreboard: compare the DUT against the model on every product_valid cycle
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (product_valid && !prev_valid) valid_rises++;
      if (product_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got product_valid=1 expected 0");
        end else begin
          int bad;
          bad = -1;
          checks++;
          for (int i = NC; i >= 0; i--) begin
            if (product[i*LW +: LW] !== exp_q[0][i*LW +: LW]) bad = i;
          end
          if (bad >= 0) begin
            errors++;
            $display("FAIL product limb %0d: got %h expected %h", bad,
                     product[bad*LW +: LW], exp_q[0][bad*LW +: LW]);
          end
          chk("overflow", LW'(overflow), LW'(exp_ov_q[0]));
          chk("coef_ready_in_hold", LW'(coef_ready), 128'd0);
          if (product_ready) begin
            last_product = product;
            last_ov      = overflow;
            void'(exp_q.pop_front());
            void'(exp_ov_q.pop_front());
          end
        end
      end
    end
    prev_valid = product_valid;
  end

  // Directed scenarios
  initial begin
    logic [CW-1:0] v;
    logic [PW-1:0] snap;
    int            r0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("coef_ready_in_reset", LW'(coef_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_coef_ready", LW'(coef_ready), 128'd1);
    chk("reset_coef_idx", LW'(coef_idx), 128'd0);
    chk("reset_valid", LW'(product_valid), 128'd0);
    chk("reset_overflow", LW'(overflow), 128'd0);
    chk("reset_product_zero", LW'(product == '0), 128'd1);

    // Square of A
    load_square();
    send_frame();
    wait_done();
    check_square("sq");

    // Carry propagation: c0 = 2^128 + 5
    clear_frame();
    v = '0;
    v[LW] = 1'b1;
    v[2:0] = 3'd5;
    frame[0] = v;
    send_frame();
    wait_done();
    chk_limb("carry_limb0", 0, 128'd5);
    chk_limb("carry_limb1", 1, 128'd1);
    chk("carry_upper_zero", LW'(last_product[PW-1:2*LW] == '0), 128'd1);
    chk("carry_ovf", LW'(last_ov), 128'd0);

    // Negative coefficient: c0 = -1, c1 = 1
    clear_frame();
    frame[0] = '1;
    frame[1] = CW'(1);
    send_frame();
    wait_done();
    chk_limb("neg_limb0", 0, {LW{1'b1}});
    chk("neg_upper_zero", LW'(last_product[PW-1:LW] == '0), 128'd1);
    chk("neg_ovf", LW'(last_ov), 128'd0);

    // Overflow: c14 = 2^256
    clear_frame();
    v = '0;
    v[2*LW] = 1'b1;
    frame[14] = v;
    send_frame();
    wait_done();
    chk_limb("ovf_limb14", 14, 128'd0);
    chk_limb("ovf_limb15", 15, 128'd0);
    chk("ovf_big", LW'(last_ov), 128'd1);

    // Overflow: c0 = -1 gives a negative total
    clear_frame();
    frame[0] = '1;
    send_frame();
    wait_done();
    chk("ovf_negative", LW'(last_ov), 128'd1);

    // Backpressure in HOLD with coef_valid asserted
    load_square();
    @(negedge clk);
    product_ready = 1'b0;
    model_push();
    for (int i = 0; i < NC; i++) send_coef(frame[i]);
    @(negedge clk);
    coef_in    = CW'(999);
    coef_valid = 1'b1;
    for (int n = 0; n < 20 && !product_valid; n++) @(negedge clk);
    #1;
    snap = product;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_held", LW'(product_valid), 128'd1);
      chk("bp_coef_ready", LW'(coef_ready), 128'd0);
      chk("bp_product_stable", LW'(product == snap), 128'd1);
    end
    @(negedge clk);
    product_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", LW'(product_valid), 128'd0);
    chk("release_coef_ready", LW'(coef_ready), 128'd1);
    chk("release_coef_idx", LW'(coef_idx), 128'd0);
    coef_valid = 1'b0;
    wait_done();
    check_square("bp");

    // Reset mid-frame after 7 accepted coefficients
    r0 = valid_rises;
    load_square();
    for (int i = 0; i < 7; i++) send_coef(frame[i]);
    @(negedge clk);
    coef_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_coef_idx", LW'(coef_idx), 128'd0);
    send_frame();
    wait_done();
    check_square("rst");
    repeat (3) @(negedge clk);
    chk("rst_valid_count", LW'(valid_rises - r0), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
